// File: rtl/cond_pkg.sv
// Shared definitions for the condition/flag execute stage.
// - Condition-code encodings (instruction bits [31:28]).
// - Bit positions of N, Z, C and V inside the 4-bit flag vector.
// - Bit positions inside the decoder's 2-bit FlagW request.
package cond_pkg;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  localparam int unsigned FLAGW_NZ = 1;
  localparam int unsigned FLAGW_CV = 0;

endpackage

// File: rtl/cond_check.sv
// Combinational condition evaluator.
// Ports:
//   Cond   [3:0] in  : instruction condition field
//   Flags  [3:0] in  : registered {N,Z,C,V}
//   CondEx       out : 1 when the condition passes (reserved 1111 never passes)
module cond_check
  import cond_pkg::*;
(
  input  logic [3:0] Cond,
  input  logic [3:0] Flags,
  output logic       CondEx
);

  logic n, z, c, v;

  assign n = Flags[FLAG_N];
  assign z = Flags[FLAG_Z];
  assign c = Flags[FLAG_C];
  assign v = Flags[FLAG_V];

  always_comb begin
    CondEx = 1'b0;
    case (Cond)
      COND_EQ: CondEx = z;
      COND_NE: CondEx = ~z;
      COND_CS: CondEx = c;
      COND_CC: CondEx = ~c;
      COND_MI: CondEx = n;
      COND_PL: CondEx = ~n;
      COND_VS: CondEx = v;
      COND_VC: CondEx = ~v;
      COND_HI: CondEx = c & ~z;
      COND_LS: CondEx = ~c | z;
      COND_GE: CondEx = (n == v);
      COND_LT: CondEx = (n != v);
      COND_GT: CondEx = ~z & (n == v);
      COND_LE: CondEx = z | (n != v);
      COND_AL: CondEx = 1'b1;
      COND_NV: CondEx = 1'b0;
      default: CondEx = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_unit.sv
// Execute-stage conditional logic: holds NZCV, gates the decoder's write and
// branch strobes on the instruction condition, and squashes the wrong-path
// instructions that follow a taken PC write.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   InstrValid          : instruction present this cycle
//   Cond[3:0]           : condition field
//   ALUFlags[3:0]       : this instruction's {N,Z,C,V} result
//   FlagW[1:0]          : flag-write request ([1] N,Z  [0] C,V)
//   PCS, RegW, MemW     : decoder strobes
//   PCSrc, RegWrite, MemWrite : gated strobes (combinational)
//   CondEx              : condition passed against registered flags
//   Flags[3:0]          : registered {N,Z,C,V}
//   Squash              : current instruction is being killed
module cond_unit
  import cond_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       InstrValid,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic [1:0] FlagW,
  input  logic       PCS,
  input  logic       RegW,
  input  logic       MemW,
  output logic       PCSrc,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       CondEx,
  output logic [3:0] Flags,
  output logic       Squash
);

  localparam int unsigned CNT_W = (FLUSH_CYCLES < 1) ? 1 : $clog2(FLUSH_CYCLES + 1);
  localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES);

  logic [3:0]       flags_q, flags_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             exec;

  cond_check u_cond_check (
    .Cond   (Cond),
    .Flags  (flags_q),
    .CondEx (CondEx)
  );

  assign Flags  = flags_q;
  assign Squash = (cnt_q != '0);

  // Reset is folded into exec so every gated strobe is low while reset is held.
  assign exec     = InstrValid & CondEx & ~Squash & ~reset;
  assign PCSrc    = PCS  & exec;
  assign RegWrite = RegW & exec;
  assign MemWrite = MemW & exec;

  always_comb begin
    flags_d = flags_q;
    if (exec && FlagW[FLAGW_NZ]) begin
      flags_d[FLAG_N] = ALUFlags[FLAG_N];
      flags_d[FLAG_Z] = ALUFlags[FLAG_Z];
    end
    if (exec && FlagW[FLAGW_CV]) begin
      flags_d[FLAG_C] = ALUFlags[FLAG_C];
      flags_d[FLAG_V] = ALUFlags[FLAG_V];
    end
  end

  // A redirect cannot happen while squashing (exec is low), so the reload and
  // the decrement are mutually exclusive; bubbles do not consume a slot.
  always_comb begin
    cnt_d = cnt_q;
    if (PCSrc) begin
      cnt_d = FLUSH_LOAD;
    end else if (Squash && InstrValid) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q <= '0;
      cnt_q   <= '0;
    end else begin
      flags_q <= flags_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_cond_unit.sv
module tb_cond_unit;

  localparam int unsigned FLUSH = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       InstrValid;
  logic [3:0] Cond;
  logic [3:0] ALUFlags;
  logic [1:0] FlagW;
  logic       PCS, RegW, MemW;
  logic       PCSrc, RegWrite, MemWrite, CondEx, Squash;
  logic [3:0] Flags;

  int tests = 0;
  int fails = 0;

  // Reference model state: flags as plain bits, remaining squash slots as int.
  logic m_n, m_z, m_c, m_v;
  int   m_left;

  cond_unit #(.FLUSH_CYCLES(FLUSH)) dut (
    .clk        (clk),
    .reset      (reset),
    .InstrValid (InstrValid),
    .Cond       (Cond),
    .ALUFlags   (ALUFlags),
    .FlagW      (FlagW),
    .PCS        (PCS),
    .RegW       (RegW),
    .MemW       (MemW),
    .PCSrc      (PCSrc),
    .RegWrite   (RegWrite),
    .MemWrite   (MemWrite),
    .CondEx     (CondEx),
    .Flags      (Flags),
    .Squash     (Squash)
  );

  always #5 clk = ~clk;

  // Architectural rule: cond[3:1] picks a predicate, cond[0] inverts it.
  function automatic logic cond_ok(input logic [3:0] cc);
    logic base;
    case (cc[3:1])
      3'd0: base = m_z;
      3'd1: base = m_c;
      3'd2: base = m_n;
      3'd3: base = m_v;
      3'd4: base = m_c && !m_z;
      3'd5: base = (m_n == m_v);
      3'd6: base = !m_z && (m_n == m_v);
      default: base = 1'b1;
    endcase
    return base ^ cc[0];
  endfunction

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic vld, input logic [3:0] cc,
                       input logic [3:0] alu, input logic [1:0] fw,
                       input logic pcs, input logic regw, input logic memw);
    reset = rst; InstrValid = vld; Cond = cc; ALUFlags = alu;
    FlagW = fw; PCS = pcs; RegW = regw; MemW = memw;
  endtask

  // Check the cycle's outputs against the model mid-cycle, then advance the
  // model across the clock edge and return 1 time unit after it.
  task automatic cycle(input string tag);
    logic ex, ok;
    @(negedge clk);
    ok = (Cond === 4'bxxxx) ? 1'b0 : cond_ok(Cond);
    ex = (InstrValid === 1'b1) && !reset && (m_left == 0) && ok;
    chk({tag, "_pcsrc"}, {3'b0, PCSrc},    {3'b0, PCS  === 1'b1 && ex});
    chk({tag, "_regw"},  {3'b0, RegWrite}, {3'b0, RegW === 1'b1 && ex});
    chk({tag, "_memw"},  {3'b0, MemWrite}, {3'b0, MemW === 1'b1 && ex});
    chk({tag, "_flags"}, Flags, {m_n, m_z, m_c, m_v});
    chk({tag, "_squash"}, {3'b0, Squash}, {3'b0, m_left != 0});
    if (!$isunknown(Cond)) chk({tag, "_condex"}, {3'b0, CondEx}, {3'b0, ok});
    @(posedge clk);
    if (reset) begin
      {m_n, m_z, m_c, m_v} = 4'b0000;
      m_left = 0;
    end else begin
      if (ex && FlagW[1]) begin m_n = ALUFlags[3]; m_z = ALUFlags[2]; end
      if (ex && FlagW[0]) begin m_c = ALUFlags[1]; m_v = ALUFlags[0]; end
      if (ex && PCS) m_left = FLUSH;
      else if (m_left > 0 && InstrValid === 1'b1) m_left--;
    end
    #1;
  endtask

  initial begin
    drive(1, 1, 4'b1110, 4'b1111, 2'b11, 1, 1, 1);
    @(posedge clk); #1;
    {m_n, m_z, m_c, m_v} = 4'b0000; m_left = 0;
    cycle("rst_gate");

    // 1: AL ADDS writes flags 0110
    drive(0, 1, 4'b1110, 4'b0110, 2'b11, 0, 1, 0); cycle("t1");
    chk("t1_flags_after", Flags, 4'b0110);

    // 2: EQ / NE store with Z set
    drive(0, 1, 4'b1110, 4'b0100, 2'b11, 0, 0, 0); cycle("t2_set");
    drive(0, 1, 4'b0000, 4'b0000, 2'b00, 0, 0, 1); cycle("t2_eq");
    drive(0, 1, 4'b0001, 4'b1111, 2'b11, 0, 0, 1); cycle("t2_ne");
    chk("t2_flags_kept", Flags, 4'b0100);

    // 3: only N,Z half written
    drive(0, 1, 4'b1110, 4'b0000, 2'b11, 0, 0, 0); cycle("t3_clr");
    drive(0, 1, 4'b1110, 4'b1011, 2'b10, 0, 0, 0); cycle("t3_nz");
    chk("t3_flags_half", Flags, 4'b1000);

    // 4: branch, then valid, bubble, valid, valid
    drive(0, 1, 4'b1110, 4'b0000, 2'b00, 1, 0, 0); cycle("t4_br");
    drive(0, 1, 4'b1110, 4'b0000, 2'b00, 0, 1, 0); cycle("t4_v1");
    drive(0, 0, 4'b1110, 4'b0000, 2'b00, 0, 1, 0); cycle("t4_bub");
    drive(0, 1, 4'b1110, 4'b0000, 2'b00, 0, 1, 0); cycle("t4_v2");
    drive(0, 1, 4'b1110, 4'b0000, 2'b00, 0, 1, 0);
    #1 chk("t4_v3_regw", {3'b0, RegWrite}, 4'b0001);
    cycle("t4_v3");

    // 5: signed compares with N,V set
    drive(0, 1, 4'b1110, 4'b1001, 2'b11, 0, 0, 0); cycle("t5_set");
    for (int i = 0; i < 5; i++) begin
      logic [3:0] ccs [5];
      ccs = '{4'b1010, 4'b1011, 4'b1100, 4'b1101, 4'b1111};
      drive(0, 1, ccs[i], 4'b0000, 2'b00, 0, 1, 0);
      #1 chk("t5_regw", {3'b0, RegWrite}, (i == 0 || i == 2) ? 4'b0001 : 4'b0000);
      cycle("t5");
    end

    // 6: reset one cycle after a taken branch
    drive(0, 1, 4'b1110, 4'b0000, 2'b00, 1, 0, 0); cycle("t6_br");
    drive(1, 1, 4'b1110, 4'b1111, 2'b11, 1, 1, 1); cycle("t6_rst");
    drive(0, 1, 4'b1110, 4'b0000, 2'b00, 0, 1, 0);
    #1 chk("t6_after_regw", {3'b0, RegWrite}, 4'b0001);
    cycle("t6_after");

    // Unknown inputs with InstrValid=0
    drive(0, 0, 4'bxxxx, 4'bxxxx, 2'bxx, 1'bx, 1'bx, 1'bx); cycle("xin");

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0), 4'($urandom),
            4'($urandom), 2'($urandom), ($urandom_range(0, 3) == 0),
            1'($urandom), 1'($urandom));
      cycle("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cond_unit.md
Name: cond_unit

Overview:
- Execute-side consumer of the main instruction decoder's control outputs. Receives FlagW, PCS, RegW and MemW.
- Holds the architectural NZCV flag register and evaluates the instruction's 4-bit condition field against it.
- Gates the write and branch strobes that reach the register file, data memory and PC mux.
- Runs a squash counter that kills the wrong-path instructions following a taken PC write.

Parameters:
FLUSH_CYCLES, 2, number of valid instructions squashed after a taken PC write (0 = no squash)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
InstrValid  input  1  an instruction is presented this cycle
Cond  input  4  instruction condition field, bits [31:28]
ALUFlags  input  4  ALU result flags {N,Z,C,V} for this instruction
FlagW  input  2  decoder flag-write request: [1] = N,Z; [0] = C,V
PCS  input  1  decoder: instruction writes PC (branch or Rd=15)
RegW  input  1  decoder: register write
MemW  input  1  decoder: memory write
PCSrc  output  1  gated PC write / redirect
RegWrite  output  1  gated register-file write
MemWrite  output  1  gated data-memory write
CondEx  output  1  condition passed (combinational, from registered flags)
Flags  output  4  current registered {N,Z,C,V}
Squash  output  1  the current instruction is being squashed

Behaviour:
- Reset (clk edge with reset=1): Flags=0000, squash counter=0.
- While reset=1, PCSrc, RegWrite and MemWrite are forced to 0. Squash and CondEx follow the state.
- CondEx is combinational from Cond and the registered Flags. The same-cycle ALUFlags value is never used. Truth table:
  - 0000 EQ: Z. 0001 NE: ~Z.
  - 0010 CS: C. 0011 CC: ~C.
  - 0100 MI: N. 0101 PL: ~N.
  - 0110 VS: V. 0111 VC: ~V.
  - 1000 HI: C&~Z. 1001 LS: ~C|Z.
  - 1010 GE: N==V. 1011 LT: N!=V.
  - 1100 GT: ~Z&(N==V). 1101 LE: Z|(N!=V).
  - 1110 AL: 1. 1111: 0 (reserved, never executes).
- Define Exec = InstrValid & CondEx & ~Squash & ~reset.
  - PCSrc = PCS & Exec.
  - RegWrite = RegW & Exec.
  - MemWrite = MemW & Exec.
  - All three are combinational, zero latency.
- Flag update, registered at the clk edge:
  - If Exec & FlagW[1]: Flags[3:2] <= ALUFlags[3:2].
  - If Exec & FlagW[0]: Flags[1:0] <= ALUFlags[1:0].
  - The two halves update independently. If neither condition holds, Flags hold.
- Squash counter, width max(1, clog2(FLUSH_CYCLES+1)):
  - Squash = (counter != 0).
  - If PCSrc=1 at the edge: counter <= FLUSH_CYCLES.
  - Else if Squash & InstrValid: counter <= counter - 1.
  - Otherwise the counter holds. Bubbles (InstrValid=0) do not consume squash slots.
  - A squashed instruction makes no writes, updates no flags and cannot assert PCSrc. A new redirect therefore cannot occur while Squash=1.
  - The counter never wraps below 0.
- FLUSH_CYCLES=0: the counter stays 0 and Squash is constantly 0.
- Back-to-back taken branches with FLUSH_CYCLES=0 reload to 0 each time; no special handling is needed.
- Flag-setting conditional instruction (e.g. SUBSEQ):
  - Its own condition is evaluated on the old flags.
  - A failed condition updates no flags.
- Reset mid-squash: the counter clears at that edge. The first instruction after reset executes normally.
- With X/invalid inputs and InstrValid=0, all gated outputs are 0 and the state holds.

Decomposition:
- Shared package cond_pkg contains:
  - Localparams for the 16 condition codes (COND_EQ … COND_AL, COND_NV).
  - Flag bit indices FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
  - FlagW bit indices FLAGW_NZ=1, FLAGW_CV=0.
- One sub-module, cond_check: purely combinational, inputs Cond[3:0] and Flags[3:0], output CondEx.
- cond_unit instantiates cond_check and owns the flag register, the squash counter and the gating.

Test Plan:
1. Reset, then an AL ADDS with ALUFlags=0110 (Z,C), FlagW=11, RegW=1.
   - Required: RegWrite=1 in the same cycle; next cycle Flags=0110.
2. Flags=0100 (Z), Cond=EQ, MemW=1, then Cond=NE, MemW=1.
   - Required: MemWrite=1, then MemWrite=0, Flags unchanged.
3. Flags=0000, FlagW=10, ALUFlags=1011.
   - Required: next cycle Flags=1000; C,V not written.
4. FLUSH_CYCLES=2, AL branch PCS=1, then valid, bubble, valid, valid instructions each with RegW=1.
   - Required: PCSrc=1 on the branch. Squash=1 with RegWrite=0 for the first and second valid instructions; the bubble holds the count. The third valid instruction gives RegWrite=1 and Squash=0.
5. Flags=1001 (N,V) with Cond=GE/LT/GT/LE and RegW=1.
   - Required: RegWrite = 1/0/1/0. Cond=1111 gives RegWrite=0.
6. reset asserted one cycle after a taken branch (counter=2).
   - Required: PCSrc/RegWrite/MemWrite=0 during reset; afterwards Squash=0, Flags=0000, and the next AL RegW instruction gives RegWrite=1.
